// File: rtl/write_combine_buffer_pkg.sv
// Shared types and address-field helpers for the write-combining buffer.
package write_combine_buffer_pkg;

  typedef enum logic [1:0] {
    WCB_IDLE,
    WCB_COLLECT,
    WCB_DRAIN
  } wcb_state_t;

  // Lowest address bit of the word offset (byte-within-word bits lie below it).
  function automatic int wcb_off_lo(input int word_w);
    return $clog2(word_w / 8);
  endfunction

  // One past the highest word-offset bit; the tag starts here.
  function automatic int wcb_off_hi(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  // Width of the word-offset field.
  function automatic int wcb_off_w(input int word_w, input int line_w);
    return wcb_off_hi(line_w) - wcb_off_lo(word_w);
  endfunction

  // Idle timer width; kept at least one bit so a disabled timeout still elaborates.
  function automatic int wcb_timer_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/write_combine_buffer_line_byte_merge.sv
// Combinational merge of one byte-enabled word into a line image and its byte mask.
module line_byte_merge #(
  parameter int WORD_W = 16,
  parameter int LINE_W = 128,
  parameter int OFF_W  = $clog2(LINE_W / WORD_W)
) (
  input  logic [LINE_W-1:0]   line_in,
  input  logic [LINE_W/8-1:0] mask_in,
  input  logic [WORD_W-1:0]   word,
  input  logic [WORD_W/8-1:0] byte_en,
  input  logic [OFF_W-1:0]    offset,
  output logic [LINE_W-1:0]   line_out,
  output logic [LINE_W/8-1:0] mask_out
);

  localparam int unsigned WB  = WORD_W / 8;
  localparam int unsigned WPL = LINE_W / WORD_W;

  // Overlay enabled bytes of the word onto the selected word slot; other bytes pass through.
  always_comb begin
    line_out = line_in;
    mask_out = mask_in;
    for (int unsigned w = 0; w < WPL; w++) begin
      if (offset == OFF_W'(w)) begin
        for (int unsigned k = 0; k < WB; k++) begin
          if (byte_en[k]) begin
            line_out[(w*WB+k)*8 +: 8] = word[k*8 +: 8];
            mask_out[w*WB+k]          = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/write_combine_buffer.sv
// Single-line write-combining buffer: collects byte-enabled word stores to one
// line and hands the merged line plus byte mask to the cache via valid/ready.
module write_combine_buffer
  import write_combine_buffer_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int WORD_W  = 16,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic [WORD_W/8-1:0] wr_byte_en,
  input  logic                flush,
  output logic                line_valid,
  input  logic                line_ready,
  output logic [ADDR_W-1:0]   line_addr,
  output logic [LINE_W-1:0]   line_data,
  output logic [LINE_W/8-1:0] line_byte_en,
  output logic                empty
);

  localparam int OFF_LO = wcb_off_lo(WORD_W);
  localparam int OFF_HI = wcb_off_hi(LINE_W);
  localparam int OFF_W  = wcb_off_w(WORD_W, LINE_W);
  localparam int TAG_W  = ADDR_W - OFF_HI;
  localparam int TMR_W  = wcb_timer_w(TIMEOUT);
  localparam int LB     = LINE_W / 8;

  wcb_state_t        state_q, state_next;
  logic [TAG_W-1:0]  tag_q, tag_next;
  logic [LINE_W-1:0] data_q, data_next;
  logic [LB-1:0]     mask_q, mask_next;
  logic [TMR_W-1:0]  timer_q, timer_next;

  logic [TAG_W-1:0]  wr_tag;
  logic [OFF_W-1:0]  wr_off;
  logic              tag_hit;
  logic [LINE_W-1:0] merged_data;
  logic [LB-1:0]     merged_mask;
  logic              timed_out;

  assign wr_tag  = wr_addr[ADDR_W-1:OFF_HI];
  assign wr_off  = wr_addr[OFF_HI-1:OFF_LO];
  assign tag_hit = (wr_tag == tag_q);

  generate
    if (OFF_LO > 0) begin : g_lo_bits
      logic unused_lo_bits;
      assign unused_lo_bits = ^wr_addr[OFF_LO-1:0];
    end
  endgenerate

  // The data/mask registers are all-zero whenever the FSM is idle, so one
  // merge against the registered image serves both the first and later stores.
  line_byte_merge #(
    .WORD_W (WORD_W),
    .LINE_W (LINE_W),
    .OFF_W  (OFF_W)
  ) u_merge (
    .line_in  (data_q),
    .mask_in  (mask_q),
    .word     (wr_data),
    .byte_en  (wr_byte_en),
    .offset   (wr_off),
    .line_out (merged_data),
    .mask_out (merged_mask)
  );

  // Idle-timeout detection; a zero TIMEOUT never fires.
  always_comb begin
    timed_out = 1'b0;
    if (TIMEOUT > 0) begin
      timed_out = (timer_q == TMR_W'(TIMEOUT - 1));
    end
  end

  // Next-state, register updates and store-port handshake.
  always_comb begin
    state_next = state_q;
    tag_next   = tag_q;
    data_next  = data_q;
    mask_next  = mask_q;
    timer_next = timer_q;
    wr_ready   = 1'b0;

    case (state_q)
      WCB_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid && (|wr_byte_en)) begin
          tag_next   = wr_tag;
          data_next  = merged_data;
          mask_next  = merged_mask;
          timer_next = '0;
          state_next = (&merged_mask) ? WCB_DRAIN : WCB_COLLECT;
        end
      end

      WCB_COLLECT: begin
        wr_ready = !(wr_valid && !tag_hit) && !flush;
        if (flush || (wr_valid && !tag_hit)) begin
          state_next = WCB_DRAIN;
        end else if (wr_valid) begin
          data_next  = merged_data;
          mask_next  = merged_mask;
          timer_next = '0;
          if (&merged_mask) begin
            state_next = WCB_DRAIN;
          end
        end else if (timed_out) begin
          state_next = WCB_DRAIN;
        end else if (TIMEOUT > 0) begin
          timer_next = timer_q + TMR_W'(1);
        end
      end

      WCB_DRAIN: begin
        if (line_ready) begin
          data_next  = '0;
          mask_next  = '0;
          timer_next = '0;
          state_next = WCB_IDLE;
        end
      end

      default: begin
        state_next = WCB_IDLE;
      end
    endcase
  end

  // State, tag, line image, mask and idle timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WCB_IDLE;
      tag_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_next;
      tag_q   <= tag_next;
      data_q  <= data_next;
      mask_q  <= mask_next;
      timer_q <= timer_next;
    end
  end

  assign line_valid   = (state_q == WCB_DRAIN);
  assign empty        = (state_q == WCB_IDLE);
  assign line_addr    = {tag_q, {OFF_HI{1'b0}}};
  assign line_data    = data_q;
  assign line_byte_en = mask_q;

  // A presented line must hold still until the consumer takes it.
  a_line_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (line_valid && !line_ready) |=>
      (line_valid && $stable(line_addr) && $stable(line_data) && $stable(line_byte_en)));

  // Stores are never accepted while a line is being handed off.
  a_no_store_in_drain: assert property (@(posedge clk) disable iff (!rst_n)
    !(line_valid && wr_ready));

endmodule

// File: tb/tb_write_combine_buffer.sv
// Directed bench for write_combine_buffer with hand-computed expected lines.
module tb_write_combine_buffer;

  logic         clk;
  logic         rst_n;
  logic         wr_valid;
  logic         wr_ready;
  logic [15:0]  wr_addr;
  logic [15:0]  wr_data;
  logic [1:0]   wr_byte_en;
  logic         flush;
  logic         line_valid;
  logic         line_ready;
  logic [15:0]  line_addr;
  logic [127:0] line_data;
  logic [15:0]  line_byte_en;
  logic         empty;

  int n_checks;
  int n_errors;

  write_combine_buffer #(
    .ADDR_W  (16),
    .WORD_W  (16),
    .LINE_W  (128),
    .TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_byte_en   (wr_byte_en),
    .flush        (flush),
    .line_valid   (line_valid),
    .line_ready   (line_ready),
    .line_addr    (line_addr),
    .line_data    (line_data),
    .line_byte_en (line_byte_en),
    .empty        (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a store and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic do_store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    bit done;
    done       = 1'b0;
    wr_valid   = 1'b1;
    wr_addr    = a;
    wr_data    = d;
    wr_byte_en = be;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (wr_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    if (!done) chk("store_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  // Wait (bounded) for a line, check its contents, then accept it.
  task automatic take_line(input string tag, input logic [15:0] a, input logic [127:0] d,
                           input logic [15:0] be);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (line_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_valid"}, seen, 1'b1);
    chk({tag, "_addr"}, line_addr, a);
    chk({tag, "_data"}, line_data, d);
    chk({tag, "_be"}, line_byte_en, be);
    chk({tag, "_wr_ready_low"}, wr_ready, 1'b0);
    line_ready = 1'b1;
    @(posedge clk);
    #1;
    line_ready = 1'b0;
    chk({tag, "_empty_after"}, empty, 1'b1);
    chk({tag, "_valid_after"}, line_valid, 1'b0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_byte_en = '0;
    flush      = 1'b0;
    line_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line_valid", line_valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_be", line_byte_en, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single store then flush.
    do_store(16'h1000, 16'hBEEF, 2'b11);
    chk("t1_not_empty", empty, 1'b0);
    flush = 1'b1;
    #1;
    chk("t1_flush_blocks_ready", wr_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    take_line("t1", 16'h1000, 128'h0000_BEEF, 16'h0003);

    // Byte-level overwrite within word 1.
    do_store(16'h1002, 16'h00AA, 2'b01);
    do_store(16'h1002, 16'h5500, 2'b10);
    do_store(16'h1002, 16'h0011, 2'b01);
    do_flush();
    take_line("t2", 16'h1000, 128'h5511_0000, 16'h000C);

    // Full line drains by itself.
    for (int i = 0; i < 8; i++) begin
      do_store(16'h2000 + 16'(2 * i), 16'hA000 + 16'(i), 2'b11);
      if (i == 6) chk("t3_not_full_yet", line_valid, 1'b0);
    end
    chk("t3_auto_drain", line_valid, 1'b1);
    take_line("t3", 16'h2000, 128'hA007_A006_A005_A004_A003_A002_A001_A000, 16'hFFFF);

    // Tag change stalls the new store until the old line is taken.
    do_store(16'h3000, 16'h1234, 2'b11);
    wr_valid   = 1'b1;
    wr_addr    = 16'h3010;
    wr_data    = 16'h5678;
    wr_byte_en = 2'b11;
    #1;
    chk("t4_mismatch_ready", wr_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("t4_drain_valid", line_valid, 1'b1);
    chk("t4_drain_addr", line_addr, 16'h3000);
    chk("t4_drain_data", line_data, 128'h1234);
    chk("t4_drain_be", line_byte_en, 16'h0003);
    @(posedge clk);
    #1;
    chk("t4_still_stalled", wr_ready, 1'b0);
    line_ready = 1'b1;
    @(posedge clk);
    #1;
    line_ready = 1'b0;
    chk("t4_idle_ready", wr_ready, 1'b1);
    chk("t4_idle_empty", empty, 1'b1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    chk("t4_retry_buffered", empty, 1'b0);
    do_flush();
    take_line("t4b", 16'h3010, 128'h5678, 16'h0003);

    // Idle timeout with a stalled consumer.
    do_store(16'h4004, 16'hCAFE, 2'b11);
    repeat (14) @(posedge clk);
    #1;
    chk("t5_no_early_timeout", line_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("t5_timeout_drain", line_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", line_valid, 1'b1);
      chk("t5_hold_data", line_data, 128'hCAFE_0000_0000);
      @(posedge clk);
      #1;
    end
    take_line("t5", 16'h4000, 128'hCAFE_0000_0000, 16'h0030);

    // Store with no byte enables is dropped; flush in IDLE does nothing.
    do_store(16'h6000, 16'hFFFF, 2'b00);
    chk("t6_zero_be_empty", empty, 1'b1);
    do_flush();
    chk("t6_idle_flush_ignored", line_valid, 1'b0);

    // Asynchronous reset while a line is pending.
    do_store(16'h5000, 16'h1111, 2'b11);
    do_flush();
    chk("t7_pending", line_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", line_valid, 1'b0);
    chk("t7_rst_empty", empty, 1'b1);
    chk("t7_rst_ready", wr_ready, 1'b1);
    chk("t7_rst_be", line_byte_en, 16'h0000);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    line_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("t7_no_line_after", line_valid, 1'b0);
    end
    line_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
